// File: rtl/multicycle_control.sv
// multicycle_control: FETCH/DECODE/EXEC/MEM/WB sequencer driving datapath controls, PC strobes, halt/trap status and a retired count
module multicycle_control #(
  parameter int MCODEBITS = 4,
  parameter int OPWIDTH   = 3,
  parameter int MEM_LAT   = 2,
  parameter int COUNTW    = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [MCODEBITS-1:0] instr,
  input  logic                 instr_valid,
  input  logic                 cond_true,
  output logic                 instr_ready,
  output logic                 UncdJmp,
  output logic                 JType,
  output logic                 IType,
  output logic                 RdMem,
  output logic                 WrMem,
  output logic                 RegWrite,
  output logic                 Movf,
  output logic [OPWIDTH-1:0]   ALUOp,
  output logic                 pc_en,
  output logic                 pc_jump,
  output logic                 flag_we,
  output logic                 halted,
  output logic                 illegal,
  output logic [COUNTW-1:0]    instr_count
);
  localparam int MW = MEM_LAT > 1 ? $clog2(MEM_LAT) : 1;
  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, HALT, TRAP} state_t;
  state_t state, nxt;
  logic [MCODEBITS-1:0] ir;
  logic [MW-1:0] mcnt;
  logic [3:0] op;
  logic [2:0] alu3;
  logic ill, is_jmp, is_cmp, is_ld, is_str, is_halt, last, act, inc;
  assign op      = ir[3:0];
  assign ill     = (ir >> 4) != '0;
  assign is_jmp  = op <= 4'd4;
  assign is_cmp  = op == 4'd12;
  assign is_ld   = op == 4'd8;
  assign is_str  = op == 4'd7;
  assign is_halt = op == 4'd11;
  assign last    = mcnt == MW'(MEM_LAT - 1);
  assign act     = state == EXEC || state == MEM || state == WB;
  // halt retires on its way into HALT even though it never raises pc_en
  assign inc     = pc_en || (state == DECODE && is_halt && !ill);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= FETCH;
      ir          <= '0;
      mcnt        <= '0;
      instr_count <= '0;
    end else begin
      state       <= nxt;
      ir          <= (state == FETCH && instr_valid) ? instr : ir;
      mcnt        <= (state == MEM && !last) ? mcnt + MW'(1) : '0;
      instr_count <= instr_count + COUNTW'(inc);
    end
  end
  always_comb begin
    nxt = state;
    case (state)
      FETCH:   nxt = instr_valid ? DECODE : FETCH;
      DECODE:  nxt = ill ? TRAP : is_halt ? HALT : EXEC;
      EXEC:    nxt = (is_jmp || is_cmp) ? FETCH : (is_ld || is_str) ? MEM : WB;
      MEM:     nxt = !last ? MEM : is_ld ? WB : FETCH;
      WB:      nxt = FETCH;
      default: nxt = state;
    endcase
  end
  always_comb begin
    alu3 = op == 4'd13 ? 3'b001 : op == 4'd6 ? 3'b011 : op == 4'd15 ? 3'b101 :
           op == 4'd9 ? 3'b110 : op == 4'd12 ? 3'b111 : 3'b000;
    instr_ready = state == FETCH;
    UncdJmp     = act && op == 4'd0;
    JType       = act && is_jmp;
    IType       = act && op >= 4'd13;
    Movf        = act && op == 4'd10;
    ALUOp       = act ? OPWIDTH'(alu3) : '0;
    RdMem       = state == MEM && is_ld;
    WrMem       = state == MEM && is_str;
    RegWrite    = state == WB;
    pc_en       = (state == EXEC && (is_jmp || is_cmp)) || (state == MEM && is_str && last) || state == WB;
    pc_jump     = state == EXEC && is_jmp && (op == 4'd0 || cond_true);
    flag_we     = state == EXEC && is_cmp;
    halted      = state == HALT || state == TRAP;
    illegal     = state == TRAP;
  end
endmodule
